// File: rtl/imm_gen_pkg.sv
// Shared opcode constants and immediate format classes for the immediate generator.
// The optional CSR-immediate decode is enabled by defining IMM_GEN_ZICSR_EN.
package imm_gen_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        NONE = 3'd0,
        I    = 3'd1,
        S    = 3'd2,
        B    = 3'd3,
        U    = 3'd4,
        J    = 3'd5,
        Z    = 3'd6
    } imm_type_e;

endpackage

// File: rtl/imm_gen_comb.sv
// Combinational instruction-to-immediate decode, extended to XLEN bits.
// Defining IMM_GEN_ZICSR_EN makes SYSTEM with inst[14]=1 yield a zero-extended Z immediate.
module imm_gen_comb
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm,
    output imm_type_e       imm_type,
    output logic            illegal
);

    logic [31:0] w_imm32;

    // Every format's sign bit lands on w_imm32[31], so extension to XLEN is uniform.
    always_comb begin
        w_imm32  = '0;
        imm_type = NONE;
        illegal  = 1'b0;
        case (inst[6:0])
            OPC_OP: ;
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_FENCE: begin
                w_imm32  = {{20{inst[31]}}, inst[31:20]};
                imm_type = I;
            end
            OPC_SYSTEM: begin
`ifdef IMM_GEN_ZICSR_EN
                if (inst[14]) begin
                    w_imm32  = {27'b0, inst[19:15]};
                    imm_type = Z;
                end else begin
                    w_imm32  = {{20{inst[31]}}, inst[31:20]};
                    imm_type = I;
                end
`else
                w_imm32  = {{20{inst[31]}}, inst[31:20]};
                imm_type = I;
`endif
            end
            OPC_STORE: begin
                w_imm32  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                imm_type = S;
            end
            OPC_BRANCH: begin
                w_imm32  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
                imm_type = B;
            end
            OPC_LUI, OPC_AUIPC: begin
                w_imm32  = {inst[31:12], 12'b0};
                imm_type = U;
            end
            OPC_JAL: begin
                w_imm32  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
                imm_type = J;
            end
            default: illegal = 1'b1;
        endcase
    end

    generate
        if (XLEN == 64) begin : g_x64
            assign imm = {{32{w_imm32[31]}}, w_imm32};
        end else begin : g_x32
            assign imm = w_imm32;
        end
    endgenerate

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decode ahead of a 2-entry main/skid buffer plus an illegal counter.
// IMM_GEN_ZICSR_EN (optional) enables the Z-type CSR immediate in the decoder.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      inst,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm,
    output imm_type_e        imm_type,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    logic [XLEN-1:0]  w_imm;
    imm_type_e        w_type;
    logic             w_ill;
    logic             w_accept;
    logic             w_load_main;

    logic             r_main_valid;
    logic [XLEN-1:0]  r_main_imm;
    imm_type_e        r_main_type;
    logic             r_main_ill;
    logic             r_skid_valid;
    logic [XLEN-1:0]  r_skid_imm;
    imm_type_e        r_skid_type;
    logic             r_skid_ill;
    logic [CNT_W-1:0] r_cnt;

    imm_gen_comb #(.XLEN(XLEN)) u_comb (
        .inst     (inst),
        .imm      (w_imm),
        .imm_type (w_type),
        .illegal  (w_ill)
    );

    // in_ready comes only from a register, so out_ready never reaches it combinationally.
    assign w_accept    = in_valid && !r_skid_valid;
    assign w_load_main = !r_main_valid || out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_main_valid <= 1'b0;
            r_main_imm   <= '0;
            r_main_type  <= NONE;
            r_main_ill   <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_imm   <= '0;
            r_skid_type  <= NONE;
            r_skid_ill   <= 1'b0;
            r_cnt        <= '0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else begin
            if (w_load_main) begin
                if (r_skid_valid) begin
                    r_main_valid <= 1'b1;
                    r_main_imm   <= r_skid_imm;
                    r_main_type  <= r_skid_type;
                    r_main_ill   <= r_skid_ill;
                    r_skid_valid <= 1'b0;
                end else if (w_accept) begin
                    r_main_valid <= 1'b1;
                    r_main_imm   <= w_imm;
                    r_main_type  <= w_type;
                    r_main_ill   <= w_ill;
                end else begin
                    r_main_valid <= 1'b0;
                end
            end else if (w_accept) begin
                r_skid_valid <= 1'b1;
                r_skid_imm   <= w_imm;
                r_skid_type  <= w_type;
                r_skid_ill   <= w_ill;
            end
            if (w_accept && w_ill && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign in_ready    = !r_skid_valid;
    assign out_valid   = r_main_valid;
    assign imm         = r_main_imm;
    assign imm_type    = r_main_type;
    assign illegal     = r_main_ill;
    assign illegal_cnt = r_cnt;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench: one XLEN=32/CNT_W=16 and one XLEN=64/CNT_W=2 instance share identical stimulus.
// Expected results (64-bit; the 32-bit instance sees the low half) are queued on acceptance.
module tb_imm_gen_pipe;
    import imm_gen_pkg::*;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] imm;
        logic [2:0]  ty;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] inst = '0;
    logic        out_ready = 1'b1;

    logic        in_ready32, out_valid32, illegal32;
    logic [31:0] imm32;
    imm_type_e   type32;
    logic [15:0] cnt32;
    logic        in_ready64, out_valid64, illegal64;
    logic [63:0] imm64;
    imm_type_e   type64;
    logic [1:0]  cnt64;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   exp_cnt16 = 0;
    int   exp_cnt2 = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .CNT_W(16)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
        .inst(inst), .out_valid(out_valid32), .out_ready(out_ready), .imm(imm32),
        .imm_type(type32), .illegal(illegal32), .illegal_cnt(cnt32)
    );

    imm_gen_pipe #(.XLEN(64), .CNT_W(2)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
        .inst(inst), .out_valid(out_valid64), .out_ready(out_ready), .imm(imm64),
        .imm_type(type64), .illegal(illegal64), .illegal_cnt(cnt64)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Monitor: every consumed output is checked against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_ready && (out_valid32 || out_valid64)) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_output: got valid with imm=0x%0h, expected no output", imm64);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("out  inst=0x%08h imm64=0x%016h type=%0d ill=%0b", e.inst, imm64, type64, illegal64);
                chk("valid32", 64'(out_valid32), 64'(1));
                chk("valid64", 64'(out_valid64), 64'(1));
                chk("imm32", 64'(imm32), {32'b0, e.imm[31:0]});
                chk("imm64", imm64, e.imm);
                chk("type32", 64'(type32), 64'(e.ty));
                chk("type64", 64'(type64), 64'(e.ty));
                chk("ill32", 64'(illegal32), 64'(e.ill));
                chk("ill64", 64'(illegal64), 64'(e.ill));
            end
        end
    end

    // Offer one instruction; entered and left at posedge+1, bounded wait on in_ready.
    task automatic send(input logic [31:0] iv, input logic [63:0] ev, input logic [2:0] ty, input logic ill);
        exp_t e;
        int waits;
        in_valid = 1'b1;
        inst     = iv;
        waits    = 0;
        @(negedge clk);
        while (!in_ready32 && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (!in_ready32) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: in_ready=0 after 50 cycles, expected 1");
        end else begin
            e.inst = iv; e.imm = ev; e.ty = ty; e.ill = ill;
            exp_q.push_back(e);
            if (ill) begin
                if (exp_cnt16 != 65535) exp_cnt16++;
                if (exp_cnt2 != 3) exp_cnt2++;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || out_valid32) && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= 100) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: %0d entries left, expected 0", exp_q.size());
        end
    endtask

    task automatic chk_cnt(input string tag);
        @(negedge clk);
        chk({tag, "_cnt16"}, 64'(cnt32), 64'(exp_cnt16));
        chk({tag, "_cnt2"}, 64'(cnt64), 64'(exp_cnt2));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(out_valid32), 64'(0));
        chk("rst_imm", imm64, 64'(0));
        chk("rst_type", 64'(type32), 64'(NONE));
        chk("rst_ill", 64'(illegal32), 64'(0));
        chk("rst_cnt", 64'(cnt32), 64'(0));
        chk("rst_in_ready", 64'(in_ready32), 64'(1));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back stream with out_ready high.
        send(32'hfffb8b93, 64'hFFFFFFFFFFFFFFFF, 3'(I), 1'b0);
        send(32'h0082a223, 64'h0000000000000004, 3'(S), 1'b0);
        send(32'h014c6463, 64'h0000000000000008, 3'(B), 1'b0);
        send(32'h7ff080e7, 64'h00000000000007FF, 3'(I), 1'b0);
        send(32'h0000006f, 64'h0000000000000000, 3'(J), 1'b0);
        send(32'h01190933, 64'h0000000000000000, 3'(NONE), 1'b0);
        @(negedge clk);
        chk("latency_valid", 64'(out_valid32), 64'(1));
        chk("latency_type", 64'(type32), 64'(NONE));
        @(posedge clk);
        #1;
        send(32'h872370b7, 64'hFFFFFFFF87237000, 3'(U), 1'b0);
        send(32'h10000917, 64'h0000000010000000, 3'(U), 1'b0);
        send(32'hfe112e23, 64'hFFFFFFFFFFFFFFFC, 3'(S), 1'b0);
        send(32'hffdff06f, 64'hFFFFFFFFFFFFFFFC, 3'(J), 1'b0);
`ifdef IMM_GEN_ZICSR_EN
        send(32'h3401d073, 64'h0000000000000003, 3'(Z), 1'b0);
`else
        send(32'h3401d073, 64'h0000000000000340, 3'(I), 1'b0);
`endif
        drain();

        // Illegal opcode, then saturation of the 2-bit counter.
        send(32'h0000007f, 64'h0, 3'(NONE), 1'b1);
        drain();
        chk_cnt("ill1");
        @(posedge clk);
        #1;
        send(32'h00000010, 64'h0, 3'(NONE), 1'b1);
        send(32'h0000007f, 64'h0, 3'(NONE), 1'b1);
        send(32'h00000000, 64'h0, 3'(NONE), 1'b1);
        send(32'h0000007f, 64'h0, 3'(NONE), 1'b1);
        drain();
        chk_cnt("ill5");
        @(posedge clk);
        #1;

        // Backpressure: two accepted, third blocked, outputs held on the first.
        out_ready = 1'b0;
        send(32'h00500093, 64'h5, 3'(I), 1'b0);
        send(32'h00600113, 64'h6, 3'(I), 1'b0);
        in_valid = 1'b1;
        inst     = 32'h00700193;
        @(negedge clk);
        chk("bp_in_ready", 64'(in_ready32), 64'(0));
        chk("bp_hold_imm", 64'(imm32), 64'h5);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_hold_imm2", imm64, 64'h5);
        chk("bp_hold_valid", 64'(out_valid64), 64'(1));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(32'h00700193, 64'h7, 3'(I), 1'b0);
        drain();

        // Flush with both entries full and an illegal input offered.
        out_ready = 1'b0;
        send(32'h00800213, 64'h8, 3'(I), 1'b0);
        send(32'h00900293, 64'h9, 3'(I), 1'b0);
        in_valid = 1'b1;
        inst     = 32'h0000007f;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("flush_valid", 64'(out_valid32), 64'(0));
        chk("flush_in_ready", 64'(in_ready32), 64'(1));
        chk("flush_cnt16", 64'(cnt32), 64'(exp_cnt16));
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Reset while an entry is buffered.
        out_ready = 1'b0;
        send(32'h00a00313, 64'hA, 3'(I), 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        exp_cnt16 = 0;
        exp_cnt2  = 0;
        @(negedge clk);
        chk("rst2_valid", 64'(out_valid32), 64'(0));
        chk("rst2_imm", 64'(imm32), 64'(0));
        chk("rst2_cnt2", 64'(cnt64), 64'(0));
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL leftover: %0d expected outputs never seen, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
